fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the combinational RV32I decoder. It holds the fetch PC and issues word requests to instruction memory over a request/grant interface. Returned words are buffered in an in-order FIFO, and one `{pc, instr}` pair is presented to decode/execute with a valid/ready handshake. The decoder's `next_pc_sel`/`addr` outputs for the consumed instruction are applied as redirects, and any stale in-flight fetches are flushed.

---
 rtl/fetch_unit.sv | 139 +++++++++++++
 tb/tb_fetch_unit.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: request/grant fetch from instruction memory, in-order
// response FIFO and redirect handling. Optional macro: FETCH_MISALIGN_CHECK_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset_i,
  output logic        imem_req_o,
  output logic [29:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic [1:0]  next_pc_sel_i,
  input  logic [31:0] addr_i,
  output logic        fault_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   fpc, fpc_n;
  logic [CW-1:0] outstanding, outstanding_n;
  logic [CW-1:0] discard, discard_n;
  logic [CW-1:0] count, count_n;
  logic [PW-1:0] head, head_n, tail, tail_n;
  logic [PW-1:0] pend_head, pend_head_n, pend_tail, pend_tail_n;
  logic          fault, fault_n;

  logic [31:0] fifo_pc    [DEPTH];
  logic [31:0] fifo_instr [DEPTH];
  logic [31:0] pend_pc    [DEPTH];

  logic        grant, resp, drop, push, pop, redirect;
  logic [31:0] target_raw, target;
  logic        use_new;
  logic        valid_n;
  logic [31:0] instr_n, pc_n;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credit check covers both in-flight and buffered words, so the FIFO never overflows
  assign imem_req_o  = !reset_i && !fault &&
                       (((CW+1)'(outstanding) + (CW+1)'(count)) < (CW+1)'(DEPTH));
  assign imem_addr_o = fpc[31:2];
  assign fault_o     = fault;

  assign grant      = imem_req_o & imem_gnt_i;
  assign resp       = imem_rvalid_i & (outstanding != '0);
  assign drop       = resp & (discard != '0);
  assign push       = resp & ~drop;
  assign pop        = instr_valid_o & instr_ready_i;
  assign redirect   = pop & next_pc_sel_i[0];
  assign target_raw = next_pc_sel_i[1] ? addr_i : (pc_o + addr_i);

`ifdef FETCH_MISALIGN_CHECK_EN
  assign target  = target_raw;
  assign fault_n = fault | (redirect & (target_raw[1:0] != 2'b00));
`else
  assign target  = target_raw & ~32'h0000_0003;
  assign fault_n = 1'b0;
`endif

  // Next-state: normal FIFO/credit bookkeeping, then redirect overrides
  always_comb begin
    outstanding_n = outstanding + CW'(grant) - CW'(resp);
    discard_n     = discard - CW'(drop);
    count_n       = count + CW'(push) - CW'(pop);
    head_n        = pop  ? ptr_inc(head) : head;
    tail_n        = push ? ptr_inc(tail) : tail;
    fpc_n         = grant ? (fpc + 32'd4) : fpc;
    pend_head_n   = resp  ? ptr_inc(pend_head) : pend_head;
    pend_tail_n   = grant ? ptr_inc(pend_tail) : pend_tail;
    if (redirect) begin
      // Every request still in flight after this edge belongs to the old path
      discard_n = outstanding_n;
      count_n   = '0;
      head_n    = '0;
      tail_n    = '0;
      fpc_n     = target;
    end
  end

  // Registered view of the FIFO head after this edge
  always_comb begin
    use_new = push && (tail == head_n);
    valid_n = (count_n != '0) && !fault_n;
    instr_n = use_new ? imem_rdata_i       : fifo_instr[head_n];
    pc_n    = use_new ? pend_pc[pend_head] : fifo_pc[head_n];
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      fpc           <= RESET_PC;
      outstanding   <= '0;
      discard       <= '0;
      count         <= '0;
      head          <= '0;
      tail          <= '0;
      pend_head     <= '0;
      pend_tail     <= '0;
      fault         <= 1'b0;
      instr_valid_o <= 1'b0;
      instr_o       <= '0;
      pc_o          <= '0;
    end else begin
      fpc           <= fpc_n;
      outstanding   <= outstanding_n;
      discard       <= discard_n;
      count         <= count_n;
      head          <= head_n;
      tail          <= tail_n;
      pend_head     <= pend_head_n;
      pend_tail     <= pend_tail_n;
      fault         <= fault_n;
      instr_valid_o <= valid_n;
      instr_o       <= instr_n;
      pc_o          <= pc_n;
    end
  end

  // Storage arrays carry no reset; occupancy is tracked by the pointers above
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[tail]    <= pend_pc[pend_head];
      fifo_instr[tail] <= imem_rdata_i;
    end
    if (grant) begin
      pend_pc[pend_tail] <= fpc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed table, corner-case sequences and
// randomized traffic against a queue-based reference model.
module tb_fetch_unit;

  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        imem_req_o;
  logic [29:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [1:0]  next_pc_sel_i = 2'b00;
  logic [31:0] addr_i = '0;
  logic        fault_o;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_i(reset_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .pc_o(pc_o),
    .next_pc_sel_i(next_pc_sel_i), .addr_i(addr_i), .fault_o(fault_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int now = 0;

  // Reference model: fetch address, in-flight requests with a drop flag, buffered pairs
  logic [31:0] m_fpc;
  logic [31:0] inf_pc[$];
  bit          inf_drop[$];
  logic [31:0] q_pc[$];
  logic [31:0] q_ins[$];
  bit          m_fault;
  // Memory model: granted word addresses in order with grant cycle
  logic [29:0] mq_addr[$];
  int          mq_cyc[$];

  typedef struct {
    bit          exp_req;
    logic [29:0] exp_addr;
    bit          exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  function automatic logic [31:0] mem_word(input logic [29:0] wa);
    return {wa[15:0], ~wa[15:0]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_req();
    return !reset_i && !m_fault && ((inf_pc.size() + q_pc.size()) < int'(DEPTH));
  endfunction

  function automatic bit m_valid();
    return (q_pc.size() > 0) && !m_fault;
  endfunction

  function automatic bit resp_avail();
    return (mq_addr.size() > 0) && (mq_cyc[0] < now);
  endfunction

  task automatic model_reset();
    m_fpc   = RESET_PC;
    m_fault = 1'b0;
    inf_pc.delete(); inf_drop.delete();
    q_pc.delete();   q_ins.delete();
    mq_addr.delete(); mq_cyc.delete();
  endtask

  task automatic check_model();
    chk("req",   32'(imem_req_o),    32'(m_req()));
    chk("addr",  32'(imem_addr_o),   32'(m_fpc[31:2]));
    chk("valid", 32'(instr_valid_o), 32'(m_valid()));
    chk("fault", 32'(fault_o),       32'(m_fault));
    if (m_valid()) begin
      chk("pc",    pc_o,    q_pc[0]);
      chk("instr", instr_o, q_ins[0]);
    end
  endtask

  // One clock: compare, drive inputs, advance model, move to next falling edge
  task automatic cycle(input bit g, input bit r, input bit rdy,
                       input logic [1:0] sel, input logic [31:0] a, input bit rst);
    bit          grant, resp, pop, d;
    logic [31:0] rd, p, pc, tgt;
    check_model();
    resp = 1'b0;
    rd   = $urandom;
    if (!rst && r && resp_avail()) begin
      resp = 1'b1;
      rd   = mem_word(mq_addr.pop_front());
      void'(mq_cyc.pop_front());
    end
    grant = !rst && g && !m_fault && ((inf_pc.size() + q_pc.size()) < int'(DEPTH));
    if (grant) begin
      mq_addr.push_back(m_fpc[31:2]);
      mq_cyc.push_back(now);
    end
    reset_i       = rst;
    imem_gnt_i    = g;
    imem_rvalid_i = resp;
    imem_rdata_i  = rd;
    instr_ready_i = rdy;
    next_pc_sel_i = sel;
    addr_i        = a;
    if (rst) begin
      model_reset();
    end else begin
      pop = m_valid() && rdy;
      p   = '0;
      if (pop) begin
        p = q_pc.pop_front();
        void'(q_ins.pop_front());
      end
      if (resp && inf_pc.size() > 0) begin
        pc = inf_pc.pop_front();
        d  = inf_drop.pop_front();
        if (!d) begin
          q_pc.push_back(pc);
          q_ins.push_back(rd);
        end
      end
      if (grant) begin
        inf_pc.push_back(m_fpc);
        inf_drop.push_back(1'b0);
        m_fpc = m_fpc + 32'd4;
      end
      if (pop && (sel == 2'b01 || sel == 2'b11)) begin
        tgt = (sel == 2'b11) ? a : p + a;
        q_pc.delete(); q_ins.delete();
        foreach (inf_drop[i]) inf_drop[i] = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
        if (tgt[1:0] != 2'b00) m_fault = 1'b1;
        m_fpc = tgt;
`else
        m_fpc = {tgt[31:2], 2'b00};
`endif
      end
    end
    @(posedge clk);
    @(negedge clk);
    now++;
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 1'b0, 2'b00, '0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 2'b00, '0, 1'b1);
    reset_i = 1'b0;
    #1;
  endtask

  task automatic wait_valid(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (instr_valid_o) begin
        seen = 1'b1;
        break;
      end
      cycle(1'b1, 1'b1, 1'b0, 2'b00, '0, 1'b0);
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  vec_t vecs[8];

  initial begin
    bit          found;
    logic [1:0]  sel;
    logic [31:0] a;

    // 1-cycle memory, ready high, straight-line code after reset release
    vecs[0] = '{1'b1, 30'd0, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 30'd1, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 30'd2, 1'b1, 32'h0};
    vecs[3] = '{1'b1, 30'd2, 1'b1, 32'h4};
    vecs[4] = '{1'b1, 30'd3, 1'b0, 32'h0};
    vecs[5] = '{1'b0, 30'd4, 1'b1, 32'h8};
    vecs[6] = '{1'b1, 30'd4, 1'b1, 32'hC};
    vecs[7] = '{1'b1, 30'd5, 1'b0, 32'h0};

    model_reset();
    @(negedge clk);
    do_reset();
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_pc",    pc_o,    32'd0);
    chk("rst_fault", 32'(fault_o), 32'd0);
    chk("rst_addr",  32'(imem_addr_o), 32'(RESET_PC[31:2]));

    for (int i = 0; i < 8; i++) begin
      chk("tbl_req",   32'(imem_req_o),    32'(vecs[i].exp_req));
      chk("tbl_addr",  32'(imem_addr_o),   32'(vecs[i].exp_addr));
      chk("tbl_valid", 32'(instr_valid_o), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        chk("tbl_pc",    pc_o,    vecs[i].exp_pc);
        chk("tbl_instr", instr_o, mem_word(vecs[i].exp_pc[31:2]));
      end
      cycle(1'b1, 1'b1, 1'b1, 2'b00, '0, 1'b0);
    end

    // Backpressure: credits run out, then drain in order
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 2'b00, '0, 1'b0);
    chk("bp_req_low", 32'(imem_req_o), 32'd0);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 1'b1, 2'b00, '0, 1'b0);

    // Taken branch at pc 8 back to 0, with an older word still in flight
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_valid() && q_pc[0] == 32'h8) begin
        cycle(1'b1, 1'b0, 1'b1, 2'b01, 32'hFFFF_FFF8, 1'b0);
        found = 1'b1;
      end else begin
        cycle(1'b1, 1'b1, 1'b1, 2'b00, '0, 1'b0);
      end
    end
    chk("br_reached", 32'(found), 32'd1);
    wait_valid("br_wait");
    chk("br_pc",    pc_o,    32'h0);
    chk("br_instr", instr_o, mem_word(30'd0));

    // Jump to absolute 0x100 while a response lands in the same cycle
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_valid() && resp_avail()) begin
        cycle(1'b1, 1'b1, 1'b1, 2'b11, 32'h0000_0100, 1'b0);
        found = 1'b1;
      end else begin
        cycle(1'b1, 1'b0, 1'b0, 2'b00, '0, 1'b0);
      end
    end
    chk("jr_reached", 32'(found), 32'd1);
    wait_valid("jr_wait");
    chk("jr_pc",    pc_o,    32'h100);
    chk("jr_instr", instr_o, mem_word(30'h40));

    // Misaligned absolute target
    cycle(1'b1, 1'b1, 1'b1, 2'b11, 32'h0000_0102, 1'b0);
`ifdef FETCH_MISALIGN_CHECK_EN
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b1, 2'b00, '0, 1'b0);
    chk("mis_fault", 32'(fault_o),       32'd1);
    chk("mis_req",   32'(imem_req_o),    32'd0);
    chk("mis_valid", 32'(instr_valid_o), 32'd0);
`else
    wait_valid("mis_wait");
    chk("mis_pc",    pc_o,    32'h100);
    chk("mis_fault", 32'(fault_o), 32'd0);
`endif

    // Reset with two requests outstanding
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 2'b00, '0, 1'b0);
    chk("mid_req_full", 32'(imem_req_o), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 2'b00, '0, 1'b1);
    chk("mid_req",   32'(imem_req_o),    32'd0);
    chk("mid_valid", 32'(instr_valid_o), 32'd0);
    chk("mid_instr", instr_o, 32'd0);
    chk("mid_pc",    pc_o,    32'd0);
    chk("mid_fault", 32'(fault_o), 32'd0);
    chk("mid_addr",  32'(imem_addr_o), 32'(RESET_PC[31:2]));
    reset_i = 1'b0;
    #1;
    chk("mid_restart_req",  32'(imem_req_o),  32'd1);
    chk("mid_restart_addr", 32'(imem_addr_o), 32'(RESET_PC[31:2]));

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      sel = 2'b00;
      a   = $urandom;
      if ($urandom_range(0, 7) == 0) begin
        sel = 2'($urandom_range(0, 3));
        if (sel == 2'b01) a = 32'(($urandom_range(0, 32) - 16) * 4);
        else              a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
`ifndef FETCH_MISALIGN_CHECK_EN
        if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3));
`endif
      end
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 4) < 3,
            $urandom_range(0, 9) < 7, sel, a, $urandom_range(0, 399) == 0);
    end
    check_model();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
